// File: rtl/test_pattern_gen.sv
// Multi-lane framed pattern source: counter, Galois PRBS, walking-one or constant
// data on CH_NUM lanes, handed out as valid/ready beats grouped into frames.
module test_pattern_gen #(
  parameter int               DSIZE  = 8,
  parameter int               CH_NUM = 2,
  parameter int               LSIZE  = 16,
  parameter logic [DSIZE-1:0] POLY   = 8'hB8
) (
  input  logic                    sys_clock,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [1:0]              mode,
  input  logic [DSIZE-1:0]        seed,
  input  logic [LSIZE-1:0]        frame_len,
  output logic [CH_NUM*DSIZE-1:0] odata,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    olast,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  localparam int W = CH_NUM * DSIZE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              cont_q, cont_d;
  logic              stop_pend_q, stop_pend_d;
  logic              olast_q, olast_d;
  logic [LSIZE-1:0]  len_m1_q, len_m1_d;
  logic [LSIZE-1:0]  beat_q, beat_d;
  logic [W-1:0]      odata_q, odata_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  // The lane register itself is the pattern state, so each mode only needs a
  // starting value and a per-lane step function.
  function automatic logic [DSIZE-1:0] init_lane(input logic [1:0] m,
                                                 input logic [DSIZE-1:0] s,
                                                 input int c);
    logic [DSIZE-1:0] v;
    int pos;
    pos = 0;
    case (m)
      2'd0: v = s + DSIZE'(c);
      2'd1: begin
        v = s ^ DSIZE'(c);
        if (v == '0) v = DSIZE'(1);
      end
      2'd2: begin
        pos = ((int'(s) % DSIZE) + c) % DSIZE;
        v = DSIZE'(1) << pos;
      end
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic logic [DSIZE-1:0] next_lane(input logic [1:0] m,
                                                 input logic [DSIZE-1:0] v);
    logic [DSIZE-1:0] n;
    case (m)
      2'd0:    n = v + DSIZE'(1);
      2'd1:    n = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
      2'd2:    n = {v[DSIZE-2:0], v[DSIZE-1]};
      default: n = v;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    olast_d     = olast_q;
    len_m1_d    = len_m1_q;
    beat_d      = beat_q;
    odata_d     = odata_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d  = RUN;
          mode_d   = mode;
          cont_d   = continuous;
          len_m1_d = (frame_len == '0) ? '0 : frame_len - LSIZE'(1);
          beat_d   = '0;
          olast_d  = (frame_len == '0) || (frame_len == LSIZE'(1));
          for (int c = 0; c < CH_NUM; c++)
            odata_d[c*DSIZE +: DSIZE] = init_lane(mode, seed, c);
        end
      end
      default: begin
        if (stop) stop_pend_d = 1'b1;
        if (oready) begin
          for (int c = 0; c < CH_NUM; c++)
            odata_d[c*DSIZE +: DSIZE] = next_lane(mode_q, odata_q[c*DSIZE +: DSIZE]);
          if (olast_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            beat_d      = '0;
            olast_d     = (len_m1_q == '0);
            // A stop arriving on the closing beat still ends the run here.
            if (!cont_q || stop_pend_q || stop) begin
              state_d = IDLE;
              olast_d = 1'b0;
            end
          end else begin
            beat_d  = beat_q + LSIZE'(1);
            olast_d = ((beat_q + LSIZE'(1)) == len_m1_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clock or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      olast_q     <= 1'b0;
      len_m1_q    <= '0;
      beat_q      <= '0;
      odata_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      olast_q     <= olast_d;
      len_m1_q    <= len_m1_d;
      beat_q      <= beat_d;
      odata_q     <= odata_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign odata     = odata_q;
  assign ovalid    = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign olast     = olast_q;
  assign frame_cnt = frame_cnt_q;

endmodule
